// File: rtl/framebuffer_writer.sv
// Buffers an (addr, color) pixel stream and writes it into a double-buffered RGB565 framebuffer,
// swapping banks at end of frame and clearing the new write bank before accepting its pixels.
module framebuffer_writer #(
  parameter int unsigned FB_SIZE     = 57600,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] addr_in,
  input  logic [15:0] color_in,
  input  logic        data_valid_in,
  output logic        ready_out,
  input  logic        frame_done_in,
  output logic [16:0] wr_addr_out,
  output logic [15:0] wr_data_out,
  output logic        wr_en_out,
  output logic        display_bank_out,
  output logic        swap_done_out,
  output logic [7:0]  drop_count_out
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(FIFO_DEPTH);
  localparam logic [15:0]  LastIdx = 16'(FB_SIZE - 1);
  localparam logic [16:0]  FbLimit = 17'(FB_SIZE);

  typedef enum logic [1:0] {StClear, StRun, StDrain, StSwap} state_e;

  state_e          state_q;
  logic [15:0]     clr_cnt_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            pending_q;
  logic            display_bank_q;
  logic            wr_en_q;
  logic [16:0]     wr_addr_q;
  logic [15:0]     wr_data_q;
  logic            swap_done_q;
  logic [7:0]      drop_cnt_q;

  logic [15:0] addr_mem  [FIFO_DEPTH];
  logic [15:0] color_mem [FIFO_DEPTH];

  logic        fifo_full, fifo_empty, push, pop, head_in_range;
  logic [15:0] head_addr, head_color;

  always_comb begin
    fifo_full     = (count_q == FullCnt);
    fifo_empty    = (count_q == '0);
    ready_out     = !fifo_full && (state_q != StDrain);
    push          = data_valid_in && ready_out;
    pop           = ((state_q == StRun) || (state_q == StDrain)) && !fifo_empty;
    head_addr     = addr_mem[rd_ptr_q];
    head_color    = color_mem[rd_ptr_q];
    head_in_range = ({1'b0, head_addr} < FbLimit);
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_in) begin
    if (push) begin
      addr_mem[wr_ptr_q]  <= addr_in;
      color_mem[wr_ptr_q] <= color_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= StClear;
      clr_cnt_q      <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      pending_q      <= 1'b0;
      display_bank_q <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      swap_done_q    <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
      wr_en_q     <= 1'b0;
      swap_done_q <= 1'b0;

      if (frame_done_in && ((state_q == StClear) || (state_q == StRun))) pending_q <= 1'b1;

      unique case (state_q)
        StClear: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= {~display_bank_q, clr_cnt_q};
          wr_data_q <= CLEAR_COLOR;
          if (clr_cnt_q == LastIdx) begin
            clr_cnt_q <= '0;
            state_q   <= StRun;
          end else begin
            clr_cnt_q <= clr_cnt_q + 16'd1;
          end
        end
        StRun, StDrain: begin
          if (pop) begin
            if (head_in_range) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= {~display_bank_q, head_addr};
              wr_data_q <= head_color;
            end else if (drop_cnt_q != 8'hFF) begin
              drop_cnt_q <= drop_cnt_q + 8'd1;
            end
          end
          if ((state_q == StRun) && (pending_q || frame_done_in)) begin
            state_q <= StDrain;
          end else if ((state_q == StDrain) && fifo_empty) begin
            // Bank flips together with the pulse so both are visible during the swap cycle.
            state_q        <= StSwap;
            display_bank_q <= ~display_bank_q;
            swap_done_q    <= 1'b1;
          end
        end
        StSwap: begin
          pending_q <= 1'b0;
          state_q   <= StClear;
        end
      endcase
    end
  end

  assign wr_en_out        = wr_en_q;
  assign wr_addr_out      = wr_addr_q;
  assign wr_data_out      = wr_data_q;
  assign display_bank_out = display_bank_q;
  assign swap_done_out    = swap_done_q;
  assign drop_count_out   = drop_cnt_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Scoreboard bench: stimulus pushes expected BRAM writes into a queue, a monitor pops and compares.
module tb_framebuffer_writer;

  localparam int unsigned FbSize   = 64;
  localparam int unsigned Depth    = 16;
  localparam logic [15:0] ClrColor = 16'h0000;

  logic        clk_in        = 1'b0;
  logic        rst_in        = 1'b1;
  logic [15:0] addr_in       = '0;
  logic [15:0] color_in      = '0;
  logic        data_valid_in = 1'b0;
  logic        frame_done_in = 1'b0;
  logic        ready_out;
  logic [16:0] wr_addr_out;
  logic [15:0] wr_data_out;
  logic        wr_en_out;
  logic        display_bank_out;
  logic        swap_done_out;
  logic [7:0]  drop_count_out;

  framebuffer_writer #(
    .FB_SIZE    (FbSize),
    .FIFO_DEPTH (Depth),
    .CLEAR_COLOR(ClrColor)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .addr_in         (addr_in),
    .color_in        (color_in),
    .data_valid_in   (data_valid_in),
    .ready_out       (ready_out),
    .frame_done_in   (frame_done_in),
    .wr_addr_out     (wr_addr_out),
    .wr_data_out     (wr_data_out),
    .wr_en_out       (wr_en_out),
    .display_bank_out(display_bank_out),
    .swap_done_out   (swap_done_out),
    .drop_count_out  (drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: ordered list of expected writes {addr17, data16} plus bank/drop state.
  logic [32:0] exp_q[$];
  logic        model_disp  = 1'b0;
  int          model_drops = 0;
  int          exp_swaps   = 0;
  int          swaps_seen  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic note_fail(input string msg);
    n_checks++;
    $display("FAIL %s", msg);
  endtask

  task automatic push_clear(input logic bank);
    for (int i = 0; i < FbSize; i++) exp_q.push_back({bank, 16'(i), ClrColor});
  endtask

  task automatic model_accept(input logic [15:0] a, input logic [15:0] c);
    if (int'(a) < FbSize) exp_q.push_back({~model_disp, a, c});
    else if (model_drops < 255) model_drops++;
  endtask

  // Monitor: every write the DUT presents must be the next expected one.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (wr_en_out) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: actual addr=%0h data=%0h, required no write",
                   wr_addr_out, wr_data_out);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr_out), 32'(e[32:16]));
          check("wr_data", 32'(wr_data_out), 32'(e[15:0]));
        end
      end
      if (swap_done_out) begin
        swaps_seen++;
        check("display_bank_at_swap", 32'(display_bank_out), 32'(model_disp));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_in        = 1'b1;
    data_valid_in = 1'b0;
    frame_done_in = 1'b0;
    exp_q.delete();
    model_disp  = 1'b0;
    model_drops = 0;
    exp_swaps   = 0;
    swaps_seen  = 0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    push_clear(1'b1);
    check("rst_wr_en", 32'(wr_en_out), 32'd0);
    check("rst_display_bank", 32'(display_bank_out), 32'd0);
    check("rst_drop_count", 32'(drop_count_out), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_wr_addr", 32'(wr_addr_out), 32'd0);
  endtask

  // Caller sits at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic offer(input logic [15:0] a, input logic [15:0] c);
    int guard = 0;
    addr_in       = a;
    color_in      = c;
    data_valid_in = 1'b1;
    while (!ready_out && guard < 1000) begin
      @(posedge clk_in); #1;
      guard++;
    end
    if (!ready_out) note_fail("offer_wait: ready_out stayed 0 for 1000 cycles (required 1)");
    else model_accept(a, c);
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
  endtask

  task automatic pulse_frame_done(input bit expect_drain);
    int guard = 0;
    frame_done_in = 1'b1;
    model_disp    = ~model_disp;
    push_clear(~model_disp);
    exp_swaps++;
    @(posedge clk_in); #1;
    frame_done_in = 1'b0;
    if (expect_drain) check("ready_low_in_drain", 32'(ready_out), 32'd0);
    while (swaps_seen < exp_swaps && guard < 2000) begin
      @(posedge clk_in); #1;
      guard++;
    end
    if (swaps_seen < exp_swaps) note_fail("swap_wait: swap_done_out not seen (required 1 pulse)");
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(posedge clk_in); #1;
      guard++;
    end
    if (exp_q.size() != 0) note_fail({tag, "_idle: expected writes never appeared"});
    repeat (Depth + 8) @(posedge clk_in);
    #1;
    check({tag, "_drop_count"}, 32'(drop_count_out), 32'(model_drops));
    check({tag, "_idle_ready"}, 32'(ready_out), 32'd1);
    check({tag, "_idle_wr_en"}, 32'(wr_en_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int block_idx;

    // Reset clear on bank 1.
    do_reset();
    wait_idle("reset_clear");

    // Single pixel with 2-edge latency.
    check("single_ready", 32'(ready_out), 32'd1);
    offer(16'd5, 16'h001F);
    check("latency_not_early", 32'(wr_en_out), 32'd0);
    @(posedge clk_in); #1;
    check("latency_wr_en", 32'(wr_en_out), 32'd1);
    check("latency_wr_addr", 32'(wr_addr_out), 32'h10005);
    wait_idle("single");

    // Out-of-range drops, then saturation.
    offer(16'd64, 16'hBEEF);
    wait_idle("drop_one");
    for (int i = 0; i < 300; i++) offer(16'($urandom_range(64, 65535)), 16'($urandom()));
    wait_idle("drop_sat");

    // Frame swap: three pixels to bank 1, clear bank 0, next-frame pixel lands in bank 0.
    for (int i = 0; i < 3; i++) offer(16'($urandom_range(0, FbSize - 1)), 16'($urandom()));
    pulse_frame_done(1'b1);
    check("bank_after_swap", 32'(display_bank_out), 32'd1);
    wait_idle("swap");
    offer(16'd2, 16'h07E0);
    wait_idle("next_frame");

    // Backpressure while the new bank is being cleared.
    pulse_frame_done(1'b0);
    block_idx = -1;
    for (int i = 0; i < 20; i++) begin
      if (!ready_out && block_idx < 0) block_idx = i;
      offer(16'(i * 3), 16'($urandom()));
    end
    check("backpressure_after_16", 32'(block_idx), 32'd16);
    wait_idle("backpressure");

    // Randomised traffic with occasional end-of-frame.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0) pulse_frame_done(1'b0);
      else if (r < 10) offer(16'($urandom_range(0, FbSize + 15)), 16'($urandom()));
      else begin
        @(posedge clk_in); #1;
      end
    end
    wait_idle("random");
    check("swap_count", 32'(swaps_seen), 32'(exp_swaps));

    // Reset in the middle of a clear with pixels queued.
    do_reset();
    for (int i = 0; i < 4; i++) offer(16'(10 + i), 16'hF800);
    repeat (26) @(posedge clk_in);
    do_reset();
    wait_idle("mid_clear_reset");

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
